pwm_generator: RTL and testbench
================================

Name: pwm_generator

Overview:
- Free-running pulse-width modulator; counter period fixed at 2^CTR_SIZE clocks.
- Output is high while the counter is below the compare value.
- Used to dim LEDs and drive similar loads.
- One instance per output channel; several instances may share clk/rst and take different compare values.

Parameters:
- CTR_SIZE, default 8: counter width in bits. Period = 2^CTR_SIZE clocks. Legal range 1..16.
- SYNC_UPDATE, default 0: 0 = compare used directly each cycle; 1 = compare sampled into a shadow register only at period wrap (glitch-free duty change).
- INVERT, default 0: 1 = pwm output polarity inverted (applied after the compare, before the output register).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- compare  input  CTR_SIZE  duty threshold, unsigned.
- pwm  output  1  registered PWM waveform.
- wrap  output  1  registered one-cycle pulse, high in the cycle after ctr holds 2^CTR_SIZE-1 (marks period start).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- While rst=1:
  - ctr = 0, pwm = INVERT, wrap = 0.
  - Shadow compare register = 0.
  - All outputs update immediately on rst assertion, with no clock needed.
- Counter:
  - Internal ctr[CTR_SIZE-1:0] increments by 1 every rising clk edge.
  - Wraps from 2^CTR_SIZE-1 to 0 with no idle cycle; no saturation.
- Active threshold cmp_eff:
  - SYNC_UPDATE=0: cmp_eff = compare (live input).
  - SYNC_UPDATE=1: cmp_eff = shadow register, which loads compare on the edge where ctr goes from 2^CTR_SIZE-1 to 0.
  - With SYNC_UPDATE=1, compare changes mid-period take effect only at the next period.
- Output register: each rising edge, pwm <= (cmp_eff > ctr) XOR INVERT, using the pre-increment ctr value. pwm therefore lags ctr by one cycle.
- Duty cycle = cmp_eff / 2^CTR_SIZE:
  - compare=0: pwm constantly low (high if INVERT).
  - compare=2^CTR_SIZE-1: high for all but one cycle per period.
  - 100% duty is not reachable, by design.
- wrap <= (ctr == 2^CTR_SIZE-1) on each edge, so wrap is high for exactly one cycle per period.
- Comparison is unsigned and exactly CTR_SIZE bits wide. No arithmetic overflow is possible.
- Reset deasserted mid-operation: counting restarts from ctr=0.
  - First edge after release: pwm = (cmp_eff > 0).
  - With SYNC_UPDATE=1 the first period uses cmp_eff=0 (output low) until the first wrap loads the shadow.
- No enable input: the block runs whenever it is out of reset.

Test Plan:
1. CTR_SIZE=3, compare=3, SYNC_UPDATE=0:
   - Stimulus: pulse rst, then release.
   - Required: pwm high 3 clocks, low 5 clocks, repeating with period 8.
   - First high sample appears on the first edge after release.
   - wrap is high once every 8 clocks.
2. CTR_SIZE=3, sweep compare 0..7 on parallel instances:
   - Required high counts per 8-cycle period equal 0,1,...,7.
   - compare=0 output never toggles.
3. Async reset mid-period:
   - Stimulus: assert rst between clock edges while pwm=1.
   - Required: pwm drops to 0 immediately, without a clock edge.
   - After release the pattern restarts at ctr=0.
4. SYNC_UPDATE=1, CTR_SIZE=3:
   - Stimulus: change compare from 2 to 6 in the middle of a period.
   - Required: the current period keeps 2 high cycles; the next period shows 6 high cycles.
   - The first period after reset is all-low.
5. INVERT=1, CTR_SIZE=3, compare=3:
   - Required: pwm low 3, high 5 per period.
   - pwm=1 during reset.
6. CTR_SIZE=8, compare=128:
   - Required: 50% duty, 128 high / 128 low.
   - wrap period is 256 clocks.

Source files
------------

// File: rtl/pwm_generator.sv
// Free-running PWM channel: output high while the counter is below the active threshold.
// Optional shadowed threshold for glitch-free duty updates and optional output inversion.
module pwm_generator #(
    parameter int CTR_SIZE    = 8,
    parameter int SYNC_UPDATE = 0,
    parameter int INVERT      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CTR_SIZE-1:0] compare,
    output logic                pwm,
    output logic                wrap
);

    localparam logic [CTR_SIZE-1:0] L_CTR_MAX = '1;
    localparam logic [CTR_SIZE-1:0] L_CTR_ONE = CTR_SIZE'(1);
    localparam logic                L_INV     = (INVERT != 0) ? 1'b1 : 1'b0;
    localparam logic                L_SYNC    = (SYNC_UPDATE != 0) ? 1'b1 : 1'b0;

    logic [CTR_SIZE-1:0] r_ctr;
    logic [CTR_SIZE-1:0] r_shadow;
    logic                r_pwm;
    logic                r_wrap;
    logic [CTR_SIZE-1:0] w_cmp_eff;
    logic                w_ctr_max;

    // Threshold selection: live compare input or the period-aligned shadow copy.
    always_comb begin
        w_cmp_eff = compare;
        if (L_SYNC) begin
            w_cmp_eff = r_shadow;
        end else begin
            w_cmp_eff = compare;
        end
    end

    assign w_ctr_max = (r_ctr == L_CTR_MAX);

    // Counter, shadow threshold and registered outputs; compare uses the pre-increment count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctr    <= '0;
            r_shadow <= '0;
            r_pwm    <= L_INV;
            r_wrap   <= 1'b0;
        end else begin
            r_ctr  <= r_ctr + L_CTR_ONE;
            r_pwm  <= (w_cmp_eff > r_ctr) ^ L_INV;
            r_wrap <= w_ctr_max;
            if (L_SYNC && w_ctr_max) begin
                r_shadow <= compare;
            end else begin
                r_shadow <= r_shadow;
            end
        end
    end

    assign pwm  = r_pwm;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: cycle scoreboard against a reference counter model,
// table-driven per-period high counts, plus async-reset and shadow-update sequences.
module tb_pwm_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cmp_a;
    logic [2:0] cmp_sync;

    logic       pwm_base, wrap_base;
    logic [7:0] pwm_sw, wrap_sw;
    logic       pwm_sync, wrap_sync;
    logic       pwm_inv, wrap_inv;
    logic       pwm_w8, wrap_w8;

    always #5 clk = ~clk;

    pwm_generator #(.CTR_SIZE(3), .SYNC_UPDATE(0), .INVERT(0)) u_base (
        .clk(clk), .rst(rst), .compare(cmp_a), .pwm(pwm_base), .wrap(wrap_base));

    for (genvar k = 0; k < 8; k++) begin : g_sw
        pwm_generator #(.CTR_SIZE(3), .SYNC_UPDATE(0), .INVERT(0)) u_sw (
            .clk(clk), .rst(rst), .compare(3'(k)), .pwm(pwm_sw[k]), .wrap(wrap_sw[k]));
    end

    pwm_generator #(.CTR_SIZE(3), .SYNC_UPDATE(1), .INVERT(0)) u_sync (
        .clk(clk), .rst(rst), .compare(cmp_sync), .pwm(pwm_sync), .wrap(wrap_sync));

    pwm_generator #(.CTR_SIZE(3), .SYNC_UPDATE(0), .INVERT(1)) u_inv (
        .clk(clk), .rst(rst), .compare(3'd3), .pwm(pwm_inv), .wrap(wrap_inv));

    pwm_generator #(.CTR_SIZE(8), .SYNC_UPDATE(0), .INVERT(0)) u_w8 (
        .clk(clk), .rst(rst), .compare(8'd128), .pwm(pwm_w8), .wrap(wrap_w8));

    typedef struct {
        logic       pwm_base;
        logic       wrap_base;
        logic [7:0] pwm_sw;
        logic       pwm_sync;
        logic       pwm_inv;
        logic       pwm_w8;
        logic       wrap_w8;
    } exp_t;

    typedef struct {
        int    sel;
        int    exp;
        string name;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       tbl[12];
    int         cnt[14];
    int         checks;
    int         errors;
    logic [7:0] m_ctr;
    logic [2:0] m_shadow;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < 14; i++) cnt[i] = 0;
    endtask

    task automatic reset_checks(input string tag);
        check1({tag, "_pwm_base"}, pwm_base, 1'b0);
        check1({tag, "_wrap_base"}, wrap_base, 1'b0);
        check8({tag, "_pwm_sw"}, pwm_sw, 8'h00);
        check8({tag, "_wrap_sw"}, wrap_sw, 8'h00);
        check1({tag, "_pwm_sync"}, pwm_sync, 1'b0);
        check1({tag, "_wrap_sync"}, wrap_sync, 1'b0);
        check1({tag, "_pwm_inv"}, pwm_inv, 1'b1);
        check1({tag, "_wrap_inv"}, wrap_inv, 1'b0);
        check1({tag, "_pwm_w8"}, pwm_w8, 1'b0);
        check1({tag, "_wrap_w8"}, wrap_w8, 1'b0);
    endtask

    // One clock: predict from the model's pre-edge state, advance, then compare the sample.
    task automatic step();
        exp_t e;
        exp_t g;
        e.pwm_base  = (cmp_a > m_ctr[2:0]);
        e.wrap_base = (m_ctr[2:0] == 3'd7);
        for (int k = 0; k < 8; k++) e.pwm_sw[k] = (3'(k) > m_ctr[2:0]);
        e.pwm_sync  = (m_shadow > m_ctr[2:0]);
        e.pwm_inv   = ~(3'd3 > m_ctr[2:0]);
        e.pwm_w8    = (8'd128 > m_ctr);
        e.wrap_w8   = (m_ctr == 8'd255);
        sb_q.push_back(e);
        if (m_ctr[2:0] == 3'd7) m_shadow = cmp_sync;
        m_ctr = m_ctr + 8'd1;
        @(posedge clk);
        @(negedge clk);
        #1;
        g = sb_q.pop_front();
        check1("pwm_base", pwm_base, g.pwm_base);
        check1("wrap_base", wrap_base, g.wrap_base);
        check8("pwm_sw", pwm_sw, g.pwm_sw);
        check8("wrap_sw", wrap_sw, {8{g.wrap_base}});
        check1("pwm_sync", pwm_sync, g.pwm_sync);
        check1("wrap_sync", wrap_sync, g.wrap_base);
        check1("pwm_inv", pwm_inv, g.pwm_inv);
        check1("wrap_inv", wrap_inv, g.wrap_base);
        check1("pwm_w8", pwm_w8, g.pwm_w8);
        check1("wrap_w8", wrap_w8, g.wrap_w8);
        for (int k = 0; k < 8; k++) cnt[k] += int'(pwm_sw[k]);
        cnt[8]  += int'(pwm_base);
        cnt[9]  += int'(wrap_base);
        cnt[10] += int'(pwm_inv);
        cnt[11] += int'(pwm_sync);
        cnt[12] += int'(pwm_w8);
        cnt[13] += int'(wrap_w8);
    endtask

    task automatic apply_table(input string tag);
        for (int i = 0; i < 12; i++) begin
            check_int({tag, "_", tbl[i].name}, cnt[tbl[i].sel], tbl[i].exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) tbl[k] = '{k, k, $sformatf("sw%0d_high", k)};
        tbl[8]  = '{8, 3, "base_high"};
        tbl[9]  = '{9, 1, "base_wraps"};
        tbl[10] = '{10, 5, "inv_high"};
        tbl[11] = '{11, 0, "sync_first_period_high"};

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        cmp_a    = 3'd3;
        cmp_sync = 3'd2;
        m_ctr    = 8'd0;
        m_shadow = 3'd0;
        clear_cnt();

        #1;
        reset_checks("rst0");
        @(negedge clk);
        #1;
        reset_checks("rst0_held");
        rst = 1'b0;

        // Period 1 after reset: exact duty per channel, sync channel still all-low.
        step();
        check1("first_high", pwm_base, 1'b1);
        repeat (7) step();
        apply_table("p1");

        // Shadowed compare change mid-period only applies from the next period.
        clear_cnt();
        repeat (4) step();
        cmp_sync = 3'd6;
        repeat (4) step();
        check_int("sync_old_period", cnt[11], 2);
        clear_cnt();
        repeat (8) step();
        check_int("sync_new_period", cnt[11], 6);

        // Asynchronous reset between edges while pwm is high.
        step();
        check1("pre_rst_high", pwm_base, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        reset_checks("async");
        m_ctr    = 8'd0;
        m_shadow = 3'd0;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_checks("async_held");
        rst = 1'b0;
        clear_cnt();
        step();
        check1("restart_first_high", pwm_base, 1'b1);
        repeat (7) step();
        apply_table("p_rst");

        // Full 256-cycle period of the 8-bit channel.
        while (m_ctr != 8'd0) step();
        clear_cnt();
        repeat (256) step();
        check_int("w8_high", cnt[12], 128);
        check_int("w8_wraps", cnt[13], 1);
        check_int("base_wraps_256", cnt[9], 32);
        check_int("sync6_high_256", cnt[11], 6 * 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
